shot_link_ctl: RTL and testbench

- Sequences the board-to-board message exchange for the two-player ship game over the shared UART transmitter.
- Arbitrates two requesters of the single TX channel: outgoing shot addresses from the game-control FSM, and hit/miss replies to the opponent's shots.
- Parses incoming frames into a received-shot strobe or a shot-result code.
- Enforces one outstanding shot at a time, with timeout and retry.

---
 rtl/link_pkg.sv | 39 +++
 rtl/shot_link_ctl_if.sv | 35 +++
 rtl/link_rx_parser.sv | 52 +++++
 rtl/shot_link_ctl.sv | 196 +++++++++++++++++++
 tb/tb_shot_link_ctl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/link_pkg.sv
// Shared constants, state encodings and the parsed-frame payload for the ship-game link.
package link_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CODE_W = 2;

  localparam logic [BYTE_W-1:0] HDR_SHOT   = 8'h53;
  localparam logic [BYTE_W-1:0] HDR_RESULT = 8'h52;

  localparam logic [CODE_W-1:0] CODE_MISS = 2'b01;
  localparam logic [CODE_W-1:0] CODE_HIT  = 2'b10;
  localparam logic [CODE_W-1:0] CODE_SUNK = 2'b11;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HDR,
    TX_HDR_W,
    TX_PLD,
    TX_PLD_W,
    TX_AWAIT
  } tx_state_e;

  typedef enum logic {
    RX_HDR,
    RX_PLD
  } rx_state_e;

  typedef enum logic {
    FRAME_SHOT,
    FRAME_RESULT
  } frame_type_e;

  typedef struct packed {
    logic               valid;
    frame_type_e        ftype;
    logic [BYTE_W-1:0]  payload;
  } rx_frame_t;

endpackage

// File: rtl/shot_link_ctl_if.sv
// Game-side request/response signals plus the UART TX/RX byte handshakes.
interface shot_link_ctl_if;
  import link_pkg::*;

  logic                shot_req;
  logic [BYTE_W-1:0]   shot_addr;
  logic                shot_busy;
  logic                resp_req;
  logic [CODE_W-1:0]   resp_code;
  logic                resp_ack;
  logic [BYTE_W-1:0]   tx_data;
  logic                tx_start;
  logic                tx_busy;
  logic                tx_done;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic                rx_shot_valid;
  logic [BYTE_W-1:0]   rx_shot_addr;
  logic                result_valid;
  logic [CODE_W-1:0]   result_code;
  logic                link_err;

  modport ctl (
    input  shot_req, shot_addr, resp_req, resp_code, tx_busy, tx_done, rx_data, rx_valid,
    output shot_busy, resp_ack, tx_data, tx_start, rx_shot_valid, rx_shot_addr,
           result_valid, result_code, link_err
  );

  modport env (
    output shot_req, shot_addr, resp_req, resp_code, tx_busy, tx_done, rx_data, rx_valid,
    input  shot_busy, resp_ack, tx_data, tx_start, rx_shot_valid, rx_shot_addr,
           result_valid, result_code, link_err
  );

endinterface

// File: rtl/link_rx_parser.sv
// Two-byte frame parser: header selects frame type, next byte is emitted as a combinational strobe.
module link_rx_parser
  import link_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output rx_frame_t          frame_c
);

  rx_state_e   state_q, state_d;
  frame_type_e ftype_q, ftype_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_HDR;
      ftype_q <= FRAME_SHOT;
    end else begin
      state_q <= state_d;
      ftype_q <= ftype_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ftype_d         = ftype_q;
    frame_c         = '0;
    frame_c.ftype   = ftype_q;
    frame_c.payload = rx_data;
    case (state_q)
      RX_HDR: begin
        if (rx_valid && (rx_data == HDR_SHOT)) begin
          ftype_d = FRAME_SHOT;
          state_d = RX_PLD;
        end else if (rx_valid && (rx_data == HDR_RESULT)) begin
          ftype_d = FRAME_RESULT;
          state_d = RX_PLD;
        end
      end
      RX_PLD: begin
        if (rx_valid) begin
          // A zero result code carries no information and is discarded.
          frame_c.valid = !((ftype_q == FRAME_RESULT) && (rx_data == '0));
          state_d       = RX_HDR;
        end
      end
      default: state_d = RX_HDR;
    endcase
  end

endmodule

// File: rtl/shot_link_ctl.sv
// Shot/reply message sequencer: arbitrates the UART TX, tracks the outstanding shot with timeout and retry.
module shot_link_ctl
  import link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic          clk,
  input  logic          rst,
  shot_link_ctl_if.ctl  bus
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  rx_frame_t frame_c;

  link_rx_parser u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (bus.rx_data),
    .rx_valid (bus.rx_valid),
    .frame_c  (frame_c)
  );

  tx_state_e           state_q, state_d;
  logic                is_reply_q, is_reply_d;
  logic                nested_q, nested_d;
  logic [BYTE_W-1:0]   shot_addr_q, shot_addr_d;
  logic [CODE_W-1:0]   resp_code_q, resp_code_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                shot_busy_q, shot_busy_d;
  logic                link_err_q, link_err_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                resp_ack_q, resp_ack_d;
  logic                result_valid_q, result_valid_d;
  logic [CODE_W-1:0]   result_code_q, result_code_d;
  logic                rx_shot_valid_q, rx_shot_valid_d;
  logic [BYTE_W-1:0]   rx_shot_addr_q, rx_shot_addr_d;
  logic                resp_go_c;
  logic                result_hit_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= TX_IDLE;
      is_reply_q      <= 1'b0;
      nested_q        <= 1'b0;
      shot_addr_q     <= '0;
      resp_code_q     <= '0;
      retry_q         <= '0;
      tmo_q           <= '0;
      shot_busy_q     <= 1'b0;
      link_err_q      <= 1'b0;
      tx_data_q       <= '0;
      tx_start_q      <= 1'b0;
      resp_ack_q      <= 1'b0;
      result_valid_q  <= 1'b0;
      result_code_q   <= '0;
      rx_shot_valid_q <= 1'b0;
      rx_shot_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      is_reply_q      <= is_reply_d;
      nested_q        <= nested_d;
      shot_addr_q     <= shot_addr_d;
      resp_code_q     <= resp_code_d;
      retry_q         <= retry_d;
      tmo_q           <= tmo_d;
      shot_busy_q     <= shot_busy_d;
      link_err_q      <= link_err_d;
      tx_data_q       <= tx_data_d;
      tx_start_q      <= tx_start_d;
      resp_ack_q      <= resp_ack_d;
      result_valid_q  <= result_valid_d;
      result_code_q   <= result_code_d;
      rx_shot_valid_q <= rx_shot_valid_d;
      rx_shot_addr_q  <= rx_shot_addr_d;
    end
  end

  // resp_req is a level held until resp_ack; ignore it during the ack cycle so one reply is not sent twice.
  assign resp_go_c    = bus.resp_req && !resp_ack_q;
  assign result_hit_c = frame_c.valid && (frame_c.ftype == FRAME_RESULT) && (state_q == TX_AWAIT);

  always_comb begin
    state_d         = state_q;
    is_reply_d      = is_reply_q;
    nested_d        = nested_q;
    shot_addr_d     = shot_addr_q;
    resp_code_d     = resp_code_q;
    retry_d         = retry_q;
    tmo_d           = tmo_q;
    shot_busy_d     = shot_busy_q;
    link_err_d      = link_err_q;
    tx_data_d       = tx_data_q;
    tx_start_d      = 1'b0;
    resp_ack_d      = 1'b0;
    result_valid_d  = 1'b0;
    result_code_d   = result_code_q;
    rx_shot_valid_d = 1'b0;
    rx_shot_addr_d  = rx_shot_addr_q;

    if (frame_c.valid && (frame_c.ftype == FRAME_SHOT)) begin
      rx_shot_valid_d = 1'b1;
      rx_shot_addr_d  = frame_c.payload;
    end

    case (state_q)
      TX_IDLE: begin
        if (resp_go_c) begin
          resp_code_d = bus.resp_code;
          is_reply_d  = 1'b1;
          nested_d    = 1'b0;
          state_d     = TX_HDR;
        end else if (bus.shot_req && !shot_busy_q && !link_err_q) begin
          shot_addr_d = bus.shot_addr;
          shot_busy_d = 1'b1;
          retry_d     = '0;
          is_reply_d  = 1'b0;
          state_d     = TX_HDR;
        end
      end
      TX_HDR: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = is_reply_q ? HDR_RESULT : HDR_SHOT;
          state_d    = TX_HDR_W;
        end
      end
      TX_HDR_W: begin
        if (bus.tx_done) state_d = TX_PLD;
      end
      TX_PLD: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = is_reply_q ? BYTE_W'(resp_code_q) : shot_addr_q;
          state_d    = TX_PLD_W;
        end
      end
      TX_PLD_W: begin
        if (bus.tx_done) begin
          if (is_reply_q) begin
            resp_ack_d = 1'b1;
            is_reply_d = 1'b0;
            nested_d   = 1'b0;
            state_d    = nested_q ? TX_AWAIT : TX_IDLE;
          end else begin
            tmo_d   = '0;
            state_d = TX_AWAIT;
          end
        end
      end
      TX_AWAIT: begin
        if (result_hit_c) begin
          result_valid_d = 1'b1;
          result_code_d  = frame_c.payload[CODE_W-1:0];
          shot_busy_d    = 1'b0;
          state_d        = TX_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = TX_HDR;
          end else begin
            link_err_d  = 1'b1;
            shot_busy_d = 1'b0;
            state_d     = TX_IDLE;
          end
        end else if (resp_go_c) begin
          // Reply nested inside the wait; the timeout count holds until we come back.
          resp_code_d = bus.resp_code;
          is_reply_d  = 1'b1;
          nested_d    = 1'b1;
          state_d     = TX_HDR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bus.shot_busy     = shot_busy_q;
  assign bus.resp_ack      = resp_ack_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.rx_shot_valid = rx_shot_valid_q;
  assign bus.rx_shot_addr  = rx_shot_addr_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_code   = result_code_q;
  assign bus.link_err      = link_err_q;

endmodule

// File: tb/tb_shot_link_ctl.sv
// Directed bench for shot_link_ctl with a cycle-stepped UART TX model (10-cycle byte time).
module tb_shot_link_ctl;

  logic clk;
  logic rst;

  shot_link_ctl_if bus ();

  shot_link_ctl #(
    .TIMEOUT_CYCLES (50),
    .MAX_RETRY      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] tx_q[$];
  int tx_cnt      = 0;
  int n_ack       = 0;
  int ack_at      = -1;
  int n_res       = 0;
  int n_rxs       = 0;
  int n_start_bsy = 0;

  // Advance one cycle; outputs are observed 1 time unit after the edge and the TX model reacts.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    if (rst) begin
      tx_cnt      = 0;
      bus.tx_busy = 1'b0;
    end else begin
      if (bus.tx_start) begin
        if (bus.tx_busy) n_start_bsy++;
        tx_q.push_back(bus.tx_data);
        bus.tx_busy = 1'b1;
        tx_cnt      = 10;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          bus.tx_done = 1'b1;
          bus.tx_busy = 1'b0;
        end
      end
      if (bus.resp_ack) begin
        n_ack++;
        ack_at = tx_q.size();
      end
      if (bus.result_valid)  n_res++;
      if (bus.rx_shot_valid) n_rxs++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int i;
    i = 0;
    while ((tx_q.size() < n) && (i < budget)) begin
      tick();
      i++;
    end
    n_checks++;
    if (tx_q.size() < n) $display("FAIL %s_timeout got=%0d bytes exp=%0d", name, tx_q.size(), n);
    else n_pass++;
  endtask

  task automatic start_shot(input logic [7:0] a);
    bus.shot_addr = a;
    bus.shot_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.shot_busy) break;
    end
    bus.shot_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    tx_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ticks(2);
    n_checks++; if (bus.shot_busy !== 1'b0) $display("FAIL rst_shot_busy got=%b exp=0", bus.shot_busy); else n_pass++;
    n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL rst_tx_start got=%b exp=0", bus.tx_start); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL rst_tx_data got=%h exp=00", bus.tx_data); else n_pass++;
    n_checks++; if (bus.link_err !== 1'b0) $display("FAIL rst_link_err got=%b exp=0", bus.link_err); else n_pass++;
    n_checks++; if ({bus.resp_ack, bus.result_valid, bus.rx_shot_valid} !== 3'b000)
      $display("FAIL rst_pulses got=%b exp=000", {bus.resp_ack, bus.result_valid, bus.rx_shot_valid}); else n_pass++;
    n_checks++; if ({bus.rx_shot_addr, bus.result_code} !== 10'h000)
      $display("FAIL rst_held got=%h exp=000", {bus.rx_shot_addr, bus.result_code}); else n_pass++;
    rst = 1'b0;
    tx_q.delete();
  endtask

  task automatic test_rx_shot();
    int base;
    base = n_rxs;
    send_rx(8'h53);
    n_checks++; if (bus.rx_shot_valid !== 1'b0) $display("FAIL rxshot_early got=%b exp=0", bus.rx_shot_valid); else n_pass++;
    send_rx(8'h47);
    n_checks++; if (bus.rx_shot_valid !== 1'b1) $display("FAIL rxshot_pulse got=%b exp=1", bus.rx_shot_valid); else n_pass++;
    n_checks++; if (bus.rx_shot_addr !== 8'h47) $display("FAIL rxshot_addr got=%h exp=47", bus.rx_shot_addr); else n_pass++;
    tick();
    n_checks++; if (bus.rx_shot_valid !== 1'b0) $display("FAIL rxshot_one_cycle got=%b exp=0", bus.rx_shot_valid); else n_pass++;
    n_checks++; if (bus.rx_shot_addr !== 8'h47) $display("FAIL rxshot_hold got=%h exp=47", bus.rx_shot_addr); else n_pass++;
    n_checks++; if (n_rxs - base !== 1) $display("FAIL rxshot_count got=%0d exp=1", n_rxs - base); else n_pass++;
    n_checks++; if (tx_q.size() !== 0) $display("FAIL rxshot_no_tx got=%0d exp=0", tx_q.size()); else n_pass++;
  endtask

  task automatic test_shot();
    tx_q.delete();
    start_shot(8'h35);
    n_checks++; if (bus.shot_busy !== 1'b1) $display("FAIL shot_busy_set got=%b exp=1", bus.shot_busy); else n_pass++;
    wait_bytes(2, 100, "shot_bytes");
    ticks(15);
    n_checks++; if ((tx_q.size() != 2) || (tx_q[0] !== 8'h53) || (tx_q[1] !== 8'h35))
      $display("FAIL shot_frame got=%p exp=53 35", tx_q); else n_pass++;
    n_checks++; if (bus.shot_busy !== 1'b1) $display("FAIL shot_busy_await got=%b exp=1", bus.shot_busy); else n_pass++;
    send_rx(8'h52);
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL result_early got=%b exp=0", bus.result_valid); else n_pass++;
    send_rx(8'h02);
    n_checks++; if (bus.result_valid !== 1'b1) $display("FAIL result_pulse got=%b exp=1", bus.result_valid); else n_pass++;
    n_checks++; if (bus.result_code !== 2'b10) $display("FAIL result_code_hit got=%b exp=10", bus.result_code); else n_pass++;
    n_checks++; if (bus.shot_busy !== 1'b0) $display("FAIL shot_busy_clear got=%b exp=0", bus.shot_busy); else n_pass++;
    tick();
    n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL result_one_cycle got=%b exp=0", bus.result_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base_ack;
    tx_q.delete();
    base_ack       = n_ack;
    bus.resp_code  = 2'b01;
    bus.resp_req   = 1'b1;
    bus.shot_addr  = 8'h12;
    bus.shot_req   = 1'b1;
    for (int i = 0; (i < 200) && (tx_q.size() < 4); i++) begin
      tick();
      if (bus.resp_ack)  bus.resp_req = 1'b0;
      if (bus.shot_busy) bus.shot_req = 1'b0;
    end
    bus.resp_req = 1'b0;
    bus.shot_req = 1'b0;
    n_checks++; if ((tx_q.size() != 4) || (tx_q[0] !== 8'h52) || (tx_q[1] !== 8'h01) || (tx_q[2] !== 8'h53) || (tx_q[3] !== 8'h12))
      $display("FAIL arb_order got=%p exp=52 01 53 12", tx_q); else n_pass++;
    n_checks++; if (n_ack - base_ack !== 1) $display("FAIL arb_ack_count got=%0d exp=1", n_ack - base_ack); else n_pass++;
    n_checks++; if (ack_at !== 2) $display("FAIL arb_ack_position got=%0d exp=2", ack_at); else n_pass++;
    ticks(15);
    send_rx(8'h52);
    send_rx(8'h01);
    n_checks++; if ({bus.result_valid, bus.result_code, bus.shot_busy} !== 4'b1010)
      $display("FAIL arb_result got=%b exp=1010", {bus.result_valid, bus.result_code, bus.shot_busy}); else n_pass++;
  endtask

  task automatic test_nested_reply();
    tx_q.delete();
    start_shot(8'h21);
    wait_bytes(2, 100, "nest_shot");
    ticks(14);
    bus.resp_code = 2'b10;
    bus.resp_req  = 1'b1;
    for (int i = 0; (i < 100) && bus.resp_req; i++) begin
      tick();
      if (bus.resp_ack) bus.resp_req = 1'b0;
    end
    bus.resp_req = 1'b0;
    n_checks++; if ((tx_q.size() != 4) || (tx_q[2] !== 8'h52) || (tx_q[3] !== 8'h02))
      $display("FAIL nest_reply_bytes got=%p exp=53 21 52 02", tx_q); else n_pass++;
    n_checks++; if (bus.shot_busy !== 1'b1) $display("FAIL nest_busy_kept got=%b exp=1", bus.shot_busy); else n_pass++;
    ticks(2);
    send_rx(8'h52);
    send_rx(8'h03);
    n_checks++; if ({bus.result_valid, bus.result_code, bus.shot_busy} !== 4'b1110)
      $display("FAIL nest_result got=%b exp=1110", {bus.result_valid, bus.result_code, bus.shot_busy}); else n_pass++;
  endtask

  task automatic test_noise();
    int base;
    tx_q.delete();
    start_shot(8'h77);
    wait_bytes(2, 100, "noise_shot");
    ticks(15);
    base = n_res;
    send_rx(8'hFF);
    send_rx(8'h00);
    send_rx(8'h52);
    send_rx(8'h00);
    n_checks++; if (n_res !== base) $display("FAIL noise_dropped got=%0d exp=%0d", n_res, base); else n_pass++;
    n_checks++; if (bus.shot_busy !== 1'b1) $display("FAIL noise_busy got=%b exp=1", bus.shot_busy); else n_pass++;
    send_rx(8'h52);
    send_rx(8'h03);
    n_checks++; if ({bus.result_valid, bus.result_code} !== 3'b111)
      $display("FAIL noise_result got=%b exp=111", {bus.result_valid, bus.result_code}); else n_pass++;
    ticks(2);
    base = n_res;
    send_rx(8'h52);
    send_rx(8'h01);
    tick();
    n_checks++; if (n_res !== base) $display("FAIL idle_result_dropped got=%0d exp=%0d", n_res, base); else n_pass++;
    n_checks++; if (bus.result_code !== 2'b11) $display("FAIL idle_code_held got=%b exp=11", bus.result_code); else n_pass++;
  endtask

  task automatic test_timeout();
    int i;
    tx_q.delete();
    start_shot(8'h99);
    i = 0;
    while (!bus.link_err && (i < 1000)) begin
      tick();
      i++;
    end
    n_checks++; if (bus.link_err !== 1'b1) $display("FAIL tmo_link_err got=%b exp=1", bus.link_err); else n_pass++;
    n_checks++; if ((tx_q.size() != 6) || (tx_q[4] !== 8'h53) || (tx_q[5] !== 8'h99))
      $display("FAIL tmo_frames got=%p exp=3x(53 99)", tx_q); else n_pass++;
    n_checks++; if (bus.shot_busy !== 1'b0) $display("FAIL tmo_busy_clear got=%b exp=0", bus.shot_busy); else n_pass++;
    bus.shot_addr = 8'h11;
    bus.shot_req  = 1'b1;
    ticks(100);
    bus.shot_req  = 1'b0;
    n_checks++; if ((tx_q.size() !== 6) || (bus.shot_busy !== 1'b0))
      $display("FAIL err_shot_ignored got=%0d bytes busy=%b exp=6 bytes busy=0", tx_q.size(), bus.shot_busy); else n_pass++;
    bus.resp_code = 2'b11;
    bus.resp_req  = 1'b1;
    for (int k = 0; (k < 100) && bus.resp_req; k++) begin
      tick();
      if (bus.resp_ack) bus.resp_req = 1'b0;
    end
    bus.resp_req = 1'b0;
    n_checks++; if ((tx_q.size() != 8) || (tx_q[6] !== 8'h52) || (tx_q[7] !== 8'h03))
      $display("FAIL err_reply_served got=%p exp=... 52 03", tx_q); else n_pass++;
    n_checks++; if (bus.link_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", bus.link_err); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    n_checks++; if (bus.link_err !== 1'b0) $display("FAIL rst_clears_err got=%b exp=0", bus.link_err); else n_pass++;
    start_shot(8'h44);
    wait_bytes(2, 100, "mid_shot");
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if ({bus.tx_start, bus.shot_busy, bus.resp_ack, bus.result_valid, bus.link_err} !== 5'b0)
      $display("FAIL mid_rst_flags got=%b exp=00000",
               {bus.tx_start, bus.shot_busy, bus.resp_ack, bus.result_valid, bus.link_err}); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL mid_rst_tx_data got=%h exp=00", bus.tx_data); else n_pass++;
    rst = 1'b0;
    ticks(30);
    n_checks++; if (tx_q.size() !== 2) $display("FAIL mid_rst_quiet got=%0d bytes exp=2", tx_q.size()); else n_pass++;
    start_shot(8'h45);
    wait_bytes(4, 100, "post_rst_shot");
    n_checks++; if ((tx_q.size() != 4) || (tx_q[2] !== 8'h53) || (tx_q[3] !== 8'h45))
      $display("FAIL post_rst_frame got=%p exp=.. 53 45", tx_q); else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.shot_req  = 1'b0;
    bus.shot_addr = 8'h00;
    bus.resp_req  = 1'b0;
    bus.resp_code = 2'b00;
    bus.tx_busy   = 1'b0;
    bus.tx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;

    test_reset();
    test_rx_shot();
    test_shot();
    test_back_to_back();
    test_nested_reply();
    test_noise();
    test_timeout();
    test_mid_reset();

    n_checks++; if (n_start_bsy !== 0) $display("FAIL tx_start_while_busy got=%0d exp=0", n_start_bsy); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
